// File: rtl/key_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : key_buffer_reader
// Description : Consumer end of the keypoint buffer. Follows the raster scan
//               position, pops the buffer head once its descriptor window is
//               complete (or once it can no longer complete), and forwards
//               matched records through a small valid/ready output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module key_buffer_reader #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int OFF_X      = 15,
  parameter int OFF_Y      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_start,
  input  logic        i_pix_valid,
  input  logic [11:0] i_head_sin,
  input  logic [11:0] i_head_cos,
  input  logic [9:0]  i_head_x,
  input  logic [9:0]  i_head_y,
  input  logic [7:0]  i_head_score,
  output logic        o_hit,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [11:0] o_sin,
  output logic [11:0] o_cos,
  output logic [9:0]  o_coor_x,
  output logic [9:0]  o_coor_y,
  output logic [7:0]  o_score,
  output logic [15:0] o_drop_cnt
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          RW      = 52;
  localparam logic [10:0] C_X_MAX = 11'(IMG_W - 1);
  localparam logic [10:0] C_Y_MAX = 11'(IMG_H - 1);
  localparam logic [10:0] C_OFF_X = 11'(OFF_X);
  localparam logic [10:0] C_OFF_Y = 11'(OFF_Y);
  localparam logic [AW:0] C_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [RW-1:0]   mem_q [FIFO_DEPTH];
  logic [RW-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic [9:0]  pos_x, pos_y;
  logic [10:0] tx_sum, ty_sum;
  logic [9:0]  tx, ty;
  logic        scan, head_ok, match, stale, full, empty, push, pop, drop;

  // Scan position of the current pixel, clamped target, and hit decisions.
  // A frame-start pixel is (0,0) regardless of the stored counters.
  always_comb begin
    pos_x   = i_frame_start ? 10'd0 : cur_x_q;
    pos_y   = i_frame_start ? 10'd0 : cur_y_q;
    tx_sum  = {1'b0, i_head_x} + C_OFF_X;
    ty_sum  = {1'b0, i_head_y} + C_OFF_Y;
    tx      = (tx_sum > C_X_MAX) ? C_X_MAX[9:0] : tx_sum[9:0];
    ty      = (ty_sum > C_Y_MAX) ? C_Y_MAX[9:0] : ty_sum[9:0];
    scan    = (state_q == ST_SCAN);
    head_ok = (i_head_score != 8'd0);
    match   = scan && i_pix_valid && head_ok && (pos_x == tx) && (pos_y == ty);
    stale   = scan && head_ok && ((ty < pos_y) || ((ty == pos_y) && (tx < pos_x)));
    full    = (count_q == C_FULL);
    empty   = (count_q == '0);
    push    = match && !full;
    pop     = !empty && i_ready;
    drop    = (stale || (match && full)) && (drop_cnt_q != 16'hFFFF);
  end

  // Next-state for FSM, scan counters, FIFO and drop counter.
  always_comb begin
    state_d    = state_q;
    cur_x_d    = pos_x;
    cur_y_d    = pos_y;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;

    if (!scan && i_frame_start) begin
      state_d = ST_SCAN;
    end

    // Pixels only advance the counters once scanning (or on the sync pixel).
    if ((scan || i_frame_start) && i_pix_valid) begin
      if (pos_x == C_X_MAX[9:0]) begin
        cur_x_d = 10'd0;
        cur_y_d = (pos_y == C_Y_MAX[9:0]) ? 10'd0 : pos_y + 10'd1;
      end else begin
        cur_x_d = pos_x + 10'd1;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = {i_head_sin, i_head_cos, i_head_x, i_head_y, i_head_score};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (AW + 1)'(1);
    end

    if (drop) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // State registers; reset empties the FIFO and returns to idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      mem_q      <= mem_d;
    end
  end

  assign o_hit      = match || stale;
  assign o_valid    = !empty;
  assign o_drop_cnt = drop_cnt_q;
  assign {o_sin, o_cos, o_coor_x, o_coor_y, o_score} = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_key_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_buffer_reader
// Description : Self-checking bench for key_buffer_reader on a reduced
//               64x48 frame; table-driven hits plus hand-written corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_buffer_reader;

  localparam int W = 64;
  localparam int H = 48;

  logic        clk = 1'b0;
  logic        i_rst, i_frame_start, i_pix_valid, i_ready;
  logic [11:0] i_head_sin, i_head_cos;
  logic [9:0]  i_head_x, i_head_y;
  logic [7:0]  i_head_score;
  logic        o_hit, o_valid;
  logic [11:0] o_sin, o_cos;
  logic [9:0]  o_coor_x, o_coor_y;
  logic [7:0]  o_score;
  logic [15:0] o_drop_cnt;

  always #5 clk = ~clk;

  key_buffer_reader #(
    .IMG_W(W), .IMG_H(H), .OFF_X(15), .OFF_Y(15), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_frame_start(i_frame_start),
    .i_pix_valid(i_pix_valid), .i_head_sin(i_head_sin), .i_head_cos(i_head_cos),
    .i_head_x(i_head_x), .i_head_y(i_head_y), .i_head_score(i_head_score),
    .o_hit(o_hit), .o_valid(o_valid), .i_ready(i_ready), .o_sin(o_sin),
    .o_cos(o_cos), .o_coor_x(o_coor_x), .o_coor_y(o_coor_y), .o_score(o_score),
    .o_drop_cnt(o_drop_cnt)
  );

  typedef struct {
    logic [11:0] sn;
    logic [11:0] cs;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  sc;
  } rec_t;

  typedef struct {
    logic [9:0]  hx;
    logic [9:0]  hy;
    logic [7:0]  sc;
    logic [11:0] sn;
    logic [11:0] cs;
    int          ex;
    int          ey;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   hit_cnt = 0;
  int   bx = 0;
  int   by = 0;
  rec_t sb[$];
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent raster position of the pixel presented in the current cycle.
  always @(posedge clk) begin
    if (i_pix_valid) begin
      if (i_frame_start) begin
        bx <= 1;
        by <= 0;
      end else if (bx == W - 1) begin
        bx <= 0;
        by <= (by == H - 1) ? 0 : by + 1;
      end else begin
        bx <= bx + 1;
      end
    end
  end

  // Hit counter and scoreboard checker for every accepted output record.
  always @(negedge clk) begin
    rec_t e;
    if (o_hit) hit_cnt++;
    if (!i_rst && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got x=%0d y=%0d expected no record", o_coor_x, o_coor_y);
      end else begin
        e = sb.pop_front();
        check("rec_sin",   64'(o_sin),    64'(e.sn));
        check("rec_cos",   64'(o_cos),    64'(e.cs));
        check("rec_x",     64'(o_coor_x), 64'(e.x));
        check("rec_y",     64'(o_coor_y), 64'(e.y));
        check("rec_score", 64'(o_score),  64'(e.sc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic [9:0] x, input logic [9:0] y, input logic [7:0] sc,
                          input logic [11:0] sn, input logic [11:0] cs);
    i_head_x = x; i_head_y = y; i_head_score = sc; i_head_sin = sn; i_head_cos = cs;
  endtask

  task automatic start_frame();
    i_frame_start = 1'b1;
    i_pix_valid   = 1'b1;
    step();
    i_frame_start = 1'b0;
  endtask

  // Stream pixels until o_hit, then check where it fired; the head empties
  // on the hit edge as the real buffer would advance.
  task automatic run_to_hit(input string name, input int ex, input int ey);
    bit found = 1'b0;
    int hx = -1;
    int hy = -1;
    i_pix_valid = 1'b1;
    for (int n = 0; n < 4000 && !found; n++) begin
      @(negedge clk);
      if (o_hit) begin
        found = 1'b1;
        hx = bx;
        hy = by;
      end
      @(posedge clk);
      #1;
    end
    i_head_score = 8'd0;
    check({name, "_found"}, 64'(found), 64'd1);
    check({name, "_x"}, 64'(hx), 64'(ex));
    check({name, "_y"}, 64'(hy), 64'(ey));
  endtask

  initial begin
    int h0;
    int n;
    rec_t r;

    vecs[0] = '{hx:10'd20, hy:10'd10, sc:8'd5, sn:12'h123, cs:12'h456, ex:35, ey:25};
    vecs[1] = '{hx:10'd55, hy:10'd10, sc:8'd6, sn:12'h7FF, cs:12'h801, ex:63, ey:25};
    vecs[2] = '{hx:10'd30, hy:10'd25, sc:8'd7, sn:12'hABC, cs:12'h0DE, ex:45, ey:40};
    vecs[3] = '{hx:10'd10, hy:10'd40, sc:8'd8, sn:12'h001, cs:12'hFFF, ex:25, ey:47};
    vecs[4] = '{hx:10'd60, hy:10'd40, sc:8'd255, sn:12'h555, cs:12'hAAA, ex:63, ey:47};

    i_rst = 1'b1; i_frame_start = 1'b0; i_pix_valid = 1'b0; i_ready = 1'b1;
    set_head(10'd0, 10'd0, 8'd0, 12'd0, 12'd0);
    repeat (3) step();
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_hit",   64'(o_hit),   64'd0);
    check("rst_drop",  64'(o_drop_cnt), 64'd0);
    check("rst_fields", 64'({o_sin, o_cos, o_coor_x, o_coor_y, o_score}), 64'd0);
    i_rst = 1'b0;
    step();

    // Table-driven hits across one frame, including clamped targets.
    h0 = hit_cnt;
    start_frame();
    for (int k = 0; k < 5; k++) begin
      set_head(vecs[k].hx, vecs[k].hy, vecs[k].sc, vecs[k].sn, vecs[k].cs);
      run_to_hit($sformatf("vec%0d", k), vecs[k].ex, vecs[k].ey);
      r = '{sn:vecs[k].sn, cs:vecs[k].cs, x:vecs[k].hx, y:vecs[k].hy, sc:vecs[k].sc};
      sb.push_back(r);
      if (k == 0) begin
        check("lat_valid", 64'(o_valid),  64'd1);
        check("lat_x",     64'(o_coor_x), 64'd20);
        check("lat_score", 64'(o_score),  64'd5);
      end
    end
    i_pix_valid = 1'b0;
    repeat (3) step();
    check("tbl_hits",  64'(hit_cnt - h0), 64'd5);
    check("tbl_drop",  64'(o_drop_cnt), 64'd0);
    check("tbl_drain", 64'(sb.size()), 64'd0);

    // Empty head at a matching position, then a stale head.
    h0 = hit_cnt;
    set_head(10'd20, 10'd10, 8'd0, 12'h111, 12'h222);
    start_frame();
    n = 0;
    while (!(bx == 40 && by == 30) && n < 5000) begin
      step();
      n++;
    end
    check("empty_nohit", 64'(hit_cnt - h0), 64'd0);
    i_pix_valid = 1'b0;
    set_head(10'd0, 10'd0, 8'd3, 12'h333, 12'h444);
    #1;
    check("stale_hit", 64'(o_hit), 64'd1);
    step();
    i_head_score = 8'd0;
    check("stale_novalid", 64'(o_valid), 64'd0);
    check("stale_drop",    64'(o_drop_cnt), 64'd1);

    // Backpressure: five matches into a four-entry FIFO.
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_ready = 1'b0;
    h0 = hit_cnt;
    start_frame();
    for (int k = 0; k < 5; k++) begin
      set_head(10'(5 * k), 10'd0, 8'(k + 1), 12'(12'h200 + k), 12'(12'h300 + k));
      run_to_hit($sformatf("bp%0d", k), 15 + 5 * k, 15);
      if (k < 4) begin
        r = '{sn:12'(12'h200 + k), cs:12'(12'h300 + k), x:10'(5 * k), y:10'd0, sc:8'(k + 1)};
        sb.push_back(r);
      end
      if (k > 0) check($sformatf("bp_stable%0d", k), 64'({o_sin, o_score}), 64'({12'h200, 8'd1}));
    end
    i_pix_valid = 1'b0;
    check("bp_hits",  64'(hit_cnt - h0), 64'd5);
    check("bp_drop",  64'(o_drop_cnt), 64'd1);
    check("bp_valid", 64'(o_valid), 64'd1);
    i_ready = 1'b1;
    repeat (6) step();
    check("bp_drain", 64'(sb.size()), 64'd0);
    check("bp_empty", 64'(o_valid), 64'd0);

    // Asynchronous reset in the middle of a drain.
    i_ready = 1'b0;
    start_frame();
    for (int k = 0; k < 2; k++) begin
      set_head(10'(5 * k), 10'd0, 8'(k + 9), 12'(12'h600 + k), 12'(12'h700 + k));
      run_to_hit($sformatf("rd%0d", k), 15 + 5 * k, 15);
      r = '{sn:12'(12'h600 + k), cs:12'(12'h700 + k), x:10'(5 * k), y:10'd0, sc:8'(k + 9)};
      sb.push_back(r);
    end
    i_pix_valid = 1'b0;
    i_ready = 1'b1;
    step();
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_valid", 64'(o_valid), 64'd0);
    check("arst_drop",  64'(o_drop_cnt), 64'd0);
    sb.delete();
    repeat (2) step();
    i_rst = 1'b0;

    // Idle: pixels without a frame start never produce a hit.
    h0 = hit_cnt;
    set_head(10'd20, 10'd10, 8'd5, 12'h321, 12'h654);
    i_pix_valid = 1'b1;
    repeat (2000) step();
    i_pix_valid = 1'b0;
    step();
    check("idle_nohit", 64'(hit_cnt - h0), 64'd0);
    check("idle_valid", 64'(o_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_buffer_reader.md
Name: key_buffer_reader

Overview:
- Consumer end of the keypoint buffer.
- Tracks the raster scan position of the pixel stream and compares it with the buffer head entry (keypoint coords, sin, cos, score).
- When the descriptor window for the head keypoint is complete, pulses the buffer's hit (pop) input and forwards the record to the matcher through a small output FIFO with valid/ready.
- Stale or unforwardable heads are flushed and counted.

Parameters:
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame.
- OFF_X, 15, column offset from keypoint to descriptor-window completion.
- OFF_Y, 15, row offset from keypoint to descriptor-window completion.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_frame_start  in  1  pulse, coincident with first pixel of a frame
- i_pix_valid  in  1  one pixel advances this cycle
- i_head_sin  in  12  buffer head sin
- i_head_cos  in  12  buffer head cos
- i_head_x  in  10  buffer head column
- i_head_y  in  10  buffer head row
- i_head_score  in  8  buffer head score; 0 = empty slot
- o_hit  out  1  pop strobe to buffer hit input
- o_valid  out  1  output record valid
- i_ready  in  1  downstream accepts record
- o_sin  out  12  record sin
- o_cos  out  12  record cos
- o_coor_x  out  10  record column
- o_coor_y  out  10  record row
- o_score  out  8  record score
- o_drop_cnt  out  16  saturating count of flushed or dropped keypoints

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst is asynchronous and active-high.
- Reset values:
  - FSM = IDLE; cur_x = cur_y = 0; FIFO empty.
  - o_valid = 0; o_sin/o_cos/o_coor_x/o_coor_y/o_score = 0; o_drop_cnt = 0; o_hit = 0.
  - Reset mid-frame discards FIFO contents and returns to IDLE.
- FSM:
  - IDLE: ignores pixels, o_hit = 0. i_frame_start → SCAN.
  - SCAN: i_frame_start re-syncs the counters (no state change).
- Scan counters (registered):
  - cur_x, cur_y give the position of the pixel presented this cycle.
  - i_frame_start && i_pix_valid: that pixel is (0,0); next is (1,0).
  - Otherwise, on i_pix_valid: cur_x increments; at IMG_W-1 it wraps to 0 and cur_y increments; cur_y wraps from IMG_H-1 to 0.
- Target position:
  - tx = min(i_head_x + OFF_X, IMG_W-1) and ty = min(i_head_y + OFF_Y, IMG_H-1).
  - Computed in 11 bits, then clamped.
- head_ok = (i_head_score != 0).
- Match (combinational): SCAN && i_pix_valid && head_ok && cur == (tx,ty).
- Stale (combinational): SCAN && head_ok && (ty < cur_y || (ty == cur_y && tx < cur_x)).
  - Evaluated regardless of i_pix_valid.
- o_hit:
  - Combinational: o_hit = match || stale.
  - At most one pulse per head entry, because the buffer advances its head on the same edge.
  - Two keypoints with the same target: the second becomes stale next cycle and is dropped.
- Push:
  - On match with FIFO not full at the start of the cycle, write {sin, cos, x, y, score} from the head inputs.
  - Match with FIFO full: o_hit still asserts (buffer must advance), record discarded, o_drop_cnt increments.
  - Stale: o_hit asserts, no push, o_drop_cnt increments.
- o_drop_cnt saturates at 16'hFFFF.
- FIFO:
  - o_valid = !empty; output fields driven from the FIFO head register.
  - Pop on o_valid && i_ready.
  - Fields are stable while o_valid && !i_ready.
  - Simultaneous push and pop when full: push refused (no bypass). When not full, both occur and the count is unchanged.
  - Push to an empty FIFO: o_valid is 1 in the next cycle (latency 1 from match to o_valid).
- Empty buffer (score 0): no hit, no push, no drop.

Test Plan:
- Head (x=20,y=10,score=5): reset, frame_start, stream pixels with i_ready=1 → o_hit exactly one cycle at cur=(35,25); o_valid next cycle with x=20, y=10, score=5, sin/cos unchanged.
- Clamp: head (x=630,y=470) → hit at (639,479); record emitted; o_drop_cnt=0.
- Stale: head (x=0,y=0) presented while cur=(100,40) → o_hit same cycle, no o_valid, o_drop_cnt=1.
- Backpressure:
  - Setup: i_ready=0; 5 matches at distinct targets with FIFO_DEPTH=4.
  - Expected: 5 o_hit pulses, o_drop_cnt=1, o_valid held with first record stable.
  - Release i_ready: 4 records drain in order.
- Reset/idle:
  - Assert i_rst mid-drain → o_valid=0 and o_drop_cnt=0 immediately (async).
  - Pixels without frame_start → no o_hit.
  - Score=0 head at a matching position → no o_hit.
